// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment scanner with prescaler, digit mask,
// PWM brightness, dead time, tear-free slot capture and polarity control.
// Ports: clk_fast, rst (sync, active-low), seg_in, digit_mask, bright
//        -> seg_en, seg_out, frame_start (all registered).
// Optional: define SEG_SCAN_BLINK_EN for blink_mask input and BLINK_FRAMES.
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 8,
  parameter int SEG_W          = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYC       = 16,
  parameter int DIM_BITS       = 4,
  parameter int EN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES   = 256
`endif
) (
  input  logic                        clk_fast,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       digit_mask,
  input  logic [DIM_BITS-1:0]         bright,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]       seg_en,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        frame_start
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int PW = (CW > DIM_BITS) ? CW : DIM_BITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  // Inactive levels; polarity is applied only at the output register.
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
  localparam logic [SEG_W-1:0] SEG_OFF =
    {SEG_W{SEG_ACTIVE_LOW != 0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SEG_W-1:0]      slot_seg_q;
  logic                  slot_vis_q;
  logic [DIM_BITS-1:0]   slot_bright_q;

  logic                  slot_start;
  logic                  last_cyc;
  logic                  frame_end;
  logic                  in_dead;
  logic                  lit;
  logic [SEG_W-1:0]      live_seg;
  logic                  live_vis;
  logic [SEG_W-1:0]      cur_seg;
  logic                  cur_vis;
  logic [DIM_BITS-1:0]   cur_bright;
  logic [NUM_DIGITS-1:0] en_raw;
  logic [SEG_W-1:0]      seg_raw;
  logic                  fs_d;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] fcnt_q;
  logic          blink_q;
`endif

  // Prescaler and digit index sequencing.
  always_comb begin
    slot_start = (presc_q == '0);
    last_cyc   = (presc_q == P_LAST);
    frame_end  = last_cyc & (idx_q == I_LAST);
    presc_d    = last_cyc ? '0 : presc_q + PW'(1);
    idx_d      = idx_q;
    if (last_cyc) begin
      idx_d = (idx_q == I_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Live slice of the current digit; only consumed at slot start.
  always_comb begin
    live_seg = '0;
    live_vis = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        live_seg = seg_in[i*SEG_W +: SEG_W];
        live_vis = digit_mask[i];
`ifdef SEG_SCAN_BLINK_EN
        live_vis = digit_mask[i] & ~(blink_mask[i] & blink_q);
`endif
      end
    end
  end

  // During the first cycle of a slot the slot registers still hold the
  // previous digit, so use the live values that are being captured.
  always_comb begin
    cur_seg    = slot_start ? live_seg : slot_seg_q;
    cur_vis    = slot_start ? live_vis : slot_vis_q;
    cur_bright = slot_start ? bright   : slot_bright_q;
  end

  generate
    if (DEAD_CYC == 0) begin : g_nodead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (presc_q < PW'(DEAD_CYC));
    end
  endgenerate

  // PWM: low prescaler bits against brightness; all-ones is always lit.
  always_comb begin
    lit = cur_vis & ~in_dead &
          (presc_q[DIM_BITS-1:0] <= cur_bright);
    en_raw  = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_raw = lit ? cur_seg : '0;
    fs_d    = slot_start & (idx_q == '0);
  end

  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      slot_seg_q    <= '0;
      slot_vis_q    <= 1'b0;
      slot_bright_q <= '0;
      seg_en        <= EN_OFF;
      seg_out       <= SEG_OFF;
      frame_start   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (slot_start) begin
        slot_seg_q    <= live_seg;
        slot_vis_q    <= live_vis;
        slot_bright_q <= bright;
      end
      seg_en      <= en_raw ^ EN_OFF;
      seg_out     <= seg_raw ^ SEG_OFF;
      frame_start <= fs_d;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  // Phase flips at a frame boundary, so a whole frame sees one phase.
  always_ff @(posedge clk_fast) begin
    if (!rst) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (frame_end) begin
      if (fcnt_q == B_LAST) begin
        fcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        fcnt_q <= fcnt_q + BW'(1);
      end
    end
  end
`else
  logic unused_fe;
  assign unused_fe = frame_end;
`endif

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux
// (4 digits, 8-cycle slots, 2 dead cycles, 2-bit brightness).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seg_in = '0;
  logic [3:0]  mask = '0;
  logic [1:0]  bright = '0;
  logic [3:0]  seg_en;
  logic [7:0]  seg_out;
  logic        frame_start;
`ifdef SEG_SCAN_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(4), .SEG_W(8), .SCAN_DIV(8), .DEAD_CYC(2),
    .DIM_BITS(2), .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk_fast(clk),
    .rst(rst),
    .seg_in(seg_in),
    .digit_mask(mask),
    .bright(bright),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_en(seg_en),
    .seg_out(seg_out),
    .frame_start(frame_start)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: cycles since reset release plus captured slot.
  logic [12:0] sb[$];
  int          t = 0;
  logic [7:0]  cap_seg = '0;
  logic        cap_m = 1'b0;
  logic [1:0]  cap_b = '0;

  // Observed statistics for directed checks.
  int          n_lit = 0;
  int          n_fs = 0;
  int          n_aa = 0;
  logic [3:0]  acc_on = '0;

  task automatic tick();
    logic [12:0] e;
    logic [3:0]  en;
    logic [7:0]  sg;
    int          p;
    int          d;
    logic        on;
    @(posedge clk);
    if (!rst) begin
      e = {4'hF, 8'h00, 1'b0};
      t = 0;
    end else begin
      p = t % 8;
      d = (t / 8) % 4;
      if (p == 0) begin
        cap_seg = seg_in[d*8 +: 8];
        cap_m   = mask[d];
        cap_b   = bright;
      end
      on = cap_m && (p >= 2) && ((p % 4) <= int'(cap_b));
      en = on ? ~(4'b0001 << d) : 4'hF;
      sg = on ? cap_seg : 8'h00;
      e  = {en, sg, (p == 0 && d == 0)};
      t++;
    end
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("seg_en", 32'(seg_en), 32'(e[12:9]));
    check("seg_out", 32'(seg_out), 32'(e[8:1]));
    check("frame_start", 32'(frame_start), 32'(e[0]));
    if (seg_en != 4'hF) n_lit++;
    if (frame_start) n_fs++;
    if (seg_en == 4'b1101 && seg_out == 8'hAA) n_aa++;
    acc_on = acc_on | ~seg_en;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_lit  = 0;
    n_fs   = 0;
    n_aa   = 0;
    acc_on = '0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    run(5);
    check("rst_en", 32'(seg_en), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h00);
    check("rst_fs", 32'(frame_start), 32'h0);

    rst    = 1'b1;
    seg_in = 32'h44332211;
    mask   = 4'hF;
    bright = 2'd3;
    clr();
    run(64);
    check("full_lit", 32'(n_lit), 32'd48);
    check("full_fs", 32'(n_fs), 32'd2);

    bright = 2'd0;
    clr();
    run(32);
    check("b0_lit", 32'(n_lit), 32'd4);
    check("b0_dead", 32'(acc_on), 32'hF);

    bright = 2'd1;
    clr();
    run(32);
    check("b1_lit", 32'(n_lit), 32'd8);

    bright = 2'd3;
    mask   = 4'b1010;
    clr();
    run(32);
    check("mask_lit", 32'(n_lit), 32'd12);
    check("mask_off", 32'(acc_on & 4'b0101), 32'h0);
    check("mask_fs", 32'(n_fs), 32'd1);

    mask = 4'hF;
    run(11);
    seg_in[15:8] = 8'hAA;
    clr();
    run(21);
    check("tear_cur", 32'(n_aa), 32'd0);
    clr();
    run(32);
    check("tear_next", 32'(n_aa), 32'd6);

    run(17);
    rst = 1'b0;
    run(1);
    check("mid_rst_en", 32'(seg_en), 32'hF);
    check("mid_rst_fs", 32'(frame_start), 32'h0);
    rst = 1'b1;
    clr();
    run(1);
    check("restart_fs", 32'(frame_start), 32'h1);
    run(39);
    check("restart_nfs", 32'(n_fs), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
